// File: rtl/veriRISCV_aon_pkg.sv
// Shared definitions for the always-on machine timer:
// register offsets, CTRL layout and a byte-lane merge helper.
package veriRISCV_aon_pkg;

    localparam logic [7:0] AON_MTIME_LO      = 8'h00;
    localparam logic [7:0] AON_MTIME_HI      = 8'h04;
    localparam logic [7:0] AON_MTIMECMP_LO   = 8'h08;
    localparam logic [7:0] AON_MTIMECMP_HI   = 8'h0C;
    localparam logic [7:0] AON_CTRL          = 8'h10;
    localparam logic [7:0] AON_MTIME_HI_SNAP = 8'h14;

    localparam int CTRL_EN_BIT = 0;
    localparam int CTRL_PS_LSB = 16;

    typedef struct packed {
        logic [15:0] prescale;
        logic [14:0] rsvd;
        logic        enable;
    } aon_ctrl_t;

    function automatic logic [31:0] be_merge(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  be
    );
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/aon_prescaler.sv
// Programmable divider producing a one-cycle tick every
// prescale+1 enabled cycles.
module aon_prescaler #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable_i,
    input  logic [W-1:0] prescale_i,
    input  logic         clear_i,
    output logic         tick_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tick_o = enable_i && (cnt_q == prescale_i);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear_i || !enable_i || tick_o) cnt_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/avalon_aon_timer.sv
// RISC-V mtime/mtimecmp machine timer on an Avalon-MM slave port:
// zero-wait writes, one-wait reads, registered mtip.
module avalon_aon_timer
    import veriRISCV_aon_pkg::*;
#(
    parameter int          PRESCALE_W = 16,
    parameter logic [63:0] MTIME_RST  = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        aon_avn_read,
    input  logic        aon_avn_write,
    input  logic [31:0] aon_avn_address,
    input  logic [3:0]  aon_avn_byte_enable,
    input  logic [31:0] aon_avn_writedata,
    output logic [31:0] aon_avn_readdata,
    output logic        aon_avn_waitrequest,
    output logic        mtip,
    output logic [63:0] mtime_o
);

    localparam logic [15:0] PS_MASK =
        16'((32'd1 << PRESCALE_W) - 32'd1);
    localparam logic [31:0] CTRL_MASK =
        {PS_MASK, 15'b0, 1'b1};

    logic [63:0] mtime_q, mtime_d;
    logic [63:0] cmp_q, cmp_d;
    aon_ctrl_t   ctrl_q, ctrl_d;
    logic [31:0] snap_q;
    logic [31:0] rdata_q, rdata_d;
    logic        rd_pending_q;
    logic        mtip_q;

    logic [7:0]  addr;
    logic        rd_en;
    logic        hit_lo, hit_hi, hit_clo, hit_chi, hit_ctrl;
    logic        tick;
    logic [63:0] inc;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        unused_addr;

    assign addr = {aon_avn_address[7:2], 2'b00};
    assign unused_addr = ^{aon_avn_address[31:8], aon_avn_address[1:0]};
    assign wd = aon_avn_writedata;
    assign be = aon_avn_byte_enable;

    // A write always wins; a read costs one stall cycle.
    assign rd_en = aon_avn_read && !aon_avn_write && !rd_pending_q;

    assign hit_lo   = aon_avn_write && (addr == AON_MTIME_LO);
    assign hit_hi   = aon_avn_write && (addr == AON_MTIME_HI);
    assign hit_clo  = aon_avn_write && (addr == AON_MTIMECMP_LO);
    assign hit_chi  = aon_avn_write && (addr == AON_MTIMECMP_HI);
    assign hit_ctrl = aon_avn_write && (addr == AON_CTRL);

    aon_prescaler #(.W(PRESCALE_W)) u_prescaler (
        .clk        (clk),
        .rst        (rst),
        .enable_i   (ctrl_q.enable),
        .prescale_i (ctrl_q.prescale[PRESCALE_W-1:0]),
        .clear_i    (hit_ctrl),
        .tick_o     (tick)
    );

    assign inc = mtime_q + 64'(tick);

    always_comb begin
        mtime_d = inc;
        cmp_d   = cmp_q;
        ctrl_d  = ctrl_q;
        if (hit_lo)  mtime_d[31:0]  = be_merge(inc[31:0], wd, be);
        if (hit_hi)  mtime_d[63:32] = be_merge(inc[63:32], wd, be);
        if (hit_clo) cmp_d[31:0]    = be_merge(cmp_q[31:0], wd, be);
        if (hit_chi) cmp_d[63:32]   = be_merge(cmp_q[63:32], wd, be);
        if (hit_ctrl)
            ctrl_d = aon_ctrl_t'(be_merge(ctrl_q, wd, be) & CTRL_MASK);
    end

    always_comb begin
        rdata_d = '0;
        case (addr)
            AON_MTIME_LO:      rdata_d = mtime_q[31:0];
            AON_MTIME_HI:      rdata_d = mtime_q[63:32];
            AON_MTIMECMP_LO:   rdata_d = cmp_q[31:0];
            AON_MTIMECMP_HI:   rdata_d = cmp_q[63:32];
            AON_CTRL:          rdata_d = ctrl_q;
            AON_MTIME_HI_SNAP: rdata_d = snap_q;
            default:           rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtime_q      <= MTIME_RST;
            cmp_q        <= '1;
            ctrl_q       <= '0;
            snap_q       <= '0;
            rdata_q      <= '0;
            rd_pending_q <= 1'b0;
            mtip_q       <= 1'b0;
        end else begin
            mtime_q      <= mtime_d;
            cmp_q        <= cmp_d;
            ctrl_q       <= ctrl_d;
            rd_pending_q <= rd_en;
            mtip_q       <= (mtime_q >= cmp_q);
            if (rd_en) rdata_q <= rdata_d;
            if (rd_en && addr == AON_MTIME_LO) snap_q <= mtime_q[63:32];
        end
    end

    assign aon_avn_readdata    = rdata_q;
    assign aon_avn_waitrequest = rd_en;
    assign mtip                = mtip_q;
    assign mtime_o             = mtime_q;

    a_no_rd_wr: assert property (
        @(posedge clk) disable iff (rst)
        !(aon_avn_read && aon_avn_write)
    );

endmodule

// File: doc/avalon_aon_timer.md
Name: avalon_aon_timer

Overview:
- Always-on (AON) timer peripheral: device 0 of the peripheral bus decoder, attached to the aon_avn_* port of the SoC Avalon bus.
- Provides the RISC-V 64-bit mtime/mtimecmp machine timer with a programmable prescaler and a registered machine-timer interrupt (mtip).
- Exports mtime for the core's time CSR.
- Avalon-MM slave: zero wait states on write, one wait state on read.

Parameters:
- PRESCALE_W, 16, width of the prescaler divide register.
- MTIME_RST, 64'h0, reset value of mtime.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- aon_avn_read  in  1  Avalon read request
- aon_avn_write  in  1  Avalon write request
- aon_avn_address  in  32  byte address; only bits [7:0] decoded
- aon_avn_byte_enable  in  4  per-byte write enable
- aon_avn_writedata  in  32  write data
- aon_avn_readdata  out  32  read data, registered
- aon_avn_waitrequest  out  1  stall
- mtip  out  1  machine timer interrupt pending, registered
- mtime_o  out  64  current mtime

Behaviour:
- Register map (offset, reset value):
  - 0x00 MTIME_LO: mtime[31:0], MTIME_RST.
  - 0x04 MTIME_HI: mtime[63:32], MTIME_RST.
  - 0x08 MTIMECMP_LO: mtimecmp[31:0], 32'hFFFFFFFF.
  - 0x0C MTIMECMP_HI: mtimecmp[63:32], 32'hFFFFFFFF.
  - 0x10 CTRL: bit0 enable (reset 0); bits[16+PRESCALE_W-1:16] prescale (reset 0).
  - 0x14 MTIME_HI_SNAP: read-only, reset 0.
- Other offsets: reads return 0; writes ignored. address[1:0] ignored.
- Reset (async assert): all registers to their reset values; prescaler counter=0; rd_pending=0; readdata=0; mtip=0. Reset asserted mid-transaction aborts the transaction; no partial write is retained.
- Write timing:
  - waitrequest=0 in the cycle write=1; the write takes effect at the next rising edge.
  - Each byte lane updates only when its byte_enable bit is 1.
  - Writes to 0x14 are ignored.
- Read timing:
  - Cycle N: read=1 and rd_pending=0 -> waitrequest=1; rd_pending set at the edge.
  - Cycle N+1: rd_pending=1 -> waitrequest=0; readdata holds the value sampled at edge N; rd_pending clears at the edge.
  - Back-to-back reads: each read takes 2 cycles.
  - With read=0, waitrequest=0.
- Read and write asserted together: the write executes with zero wait states and the read is ignored (protocol violation; flagged by an assertion).
- Snapshot: a read of MTIME_LO captures mtime[63:32] into MTIME_HI_SNAP at the same edge it samples mtime[31:0], giving an atomic 64-bit read as LO then SNAP.
- Prescaler and tick:
  - Active only while enable=1.
  - When the counter equals prescale: tick=1 and the counter returns to 0; otherwise the counter increments.
  - prescale=0 gives a tick every cycle.
  - enable=0 holds the counter at 0 and produces no tick.
  - Writing CTRL resets the counter to 0.
- mtime update:
  - next = mtime + tick, a full 64-bit add: the LO carry propagates into HI, and 2^64-1 wraps to 0.
  - A write to MTIME_LO/HI in the same cycle as a tick: written bytes take writedata; unwritten bytes take the incremented value.
- mtip:
  - Registered: mtip <= (mtime >= mtimecmp), unsigned 64-bit compare on the current register values; one-cycle latency after any change.
  - Writing mtimecmp greater than mtime clears mtip on the following cycle.
- mtime_o: the mtime register, driven directly.

Decomposition:
- Shared package veriRISCV_aon_pkg:
  - offset localparams AON_MTIME_LO, AON_MTIME_HI, AON_MTIMECMP_LO, AON_MTIMECMP_HI, AON_CTRL, AON_MTIME_HI_SNAP;
  - CTRL bit-field positions;
  - a packed aon_ctrl_t struct.
- One sub-module, aon_prescaler:
  - inputs: enable, prescale, clear;
  - output: tick.
- Register file, Avalon handshake and compare stay in the top module.

Test Plan:
- Reset, then read each offset -> readdata 0, 0, FFFFFFFF, FFFFFFFF, 0, 0; mtip=0; each read shows waitrequest=1 for exactly 1 cycle.
- CTRL=0x0003_0001 (prescale 3, enable) -> mtime increments once every 4 clk; after 40 cycles mtime=10.
- mtime=0xFFFFFFFF (HI=0), prescale 0, enable -> next cycle LO=0, HI=1; read LO then SNAP returns 0x00000000 / 0x00000001 consistently.
- mtimecmp=20, mtime=0, prescale 0, enable -> mtip rises 1 cycle after mtime reaches 20; then write MTIMECMP_LO=100 -> mtip=0 one cycle later.
- Write MTIME_LO=0xAABBCCDD with byte_enable=4'b0101 over LO=0x11223344 -> LO=0x11BB33DD; repeat with a coincident tick -> the unwritten bytes take the incremented value.
- Assert rst asynchronously during the wait cycle of a read with mtime nonzero -> all outputs return to reset values immediately, with no edge required; the next read completes normally.
